// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: requests one aligned block from pipelined memory,
// writes each returned word into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [AWIDTH-1:0] miss_address,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              data_wr,
  output logic [AWIDTH-1:0] data_wr_addr,
  output logic [DWIDTH-1:0] data_wr_data,
  output logic              tag_wr,
  output logic              fill_done
);

  localparam int OFS = $clog2(2 * WORDS);
  localparam int CW  = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_TAG} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AWIDTH-1:0] r_base;
  logic [CW-1:0]     r_req_cnt;
  logic [CW-1:0]     r_rcv_cnt;
  logic              w_req_active;
  logic              w_wr;
  logic [AWIDTH-1:0] w_req_ofs;
  logic [AWIDTH-1:0] w_rcv_ofs;

  assign w_req_active = (r_state == S_FILL) && (r_req_cnt < CNT_LAST);
  assign w_wr         = (r_state == S_FILL) && mem_data_valid;
  // Byte offset of word k is 2*k; base is block aligned so no carry into the tag.
  assign w_req_ofs    = AWIDTH'({r_req_cnt, 1'b0});
  assign w_rcv_ofs    = AWIDTH'({r_rcv_cnt, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rcv_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          r_req_cnt <= '0;
          r_rcv_cnt <= '0;
          if (miss_detected) begin
            r_base <= {miss_address[AWIDTH-1:OFS], {OFS{1'b0}}};
          end
        end
        S_FILL: begin
          if (w_req_active) begin
            r_req_cnt <= r_req_cnt + 1'b1;
          end
          if (w_wr) begin
            r_rcv_cnt <= r_rcv_cnt + 1'b1;
          end
        end
        default: begin
          r_req_cnt <= r_req_cnt;
          r_rcv_cnt <= r_rcv_cnt;
        end
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    fsm_busy     = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = r_base;
    data_wr      = 1'b0;
    data_wr_addr = r_base;
    data_wr_data = '0;
    tag_wr       = 1'b0;
    fill_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_detected) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        fsm_busy     = 1'b1;
        mem_rd_en    = w_req_active;
        if (w_req_active) begin
          mem_addr = r_base + w_req_ofs;
        end
        data_wr      = w_wr;
        data_wr_addr = r_base + w_rcv_ofs;
        data_wr_data = mem_data;
        // Leave on the edge that accepts the final word of the block.
        if (w_wr && (r_rcv_cnt == CNT_PENULT)) begin
          w_state_next = S_TAG;
        end
      end
      S_TAG: begin
        fsm_busy     = 1'b1;
        tag_wr       = 1'b1;
        fill_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: randomized memory timing checked
// against a queue-based block-fill model, plus a directed WORDS=2 instance.
module tb_cache_fill_fsm;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          miss_detected = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_data_valid = 1'b0;
  logic          fsm_busy, mem_rd_en, data_wr, tag_wr, fill_done;
  logic [AW-1:0] mem_addr, data_wr_addr;
  logic [DW-1:0] data_wr_data;

  logic          miss_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] data_b = '0;
  logic          valid_b = 1'b0;
  logic          busy_b, rd_en_b, wr_b, tag_b, done_b;
  logic [AW-1:0] mem_addr_b, wr_addr_b;
  logic [DW-1:0] wr_data_b;

  cache_fill_fsm #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(W)) u_dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .fsm_busy(fsm_busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .data_wr(data_wr),
    .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data), .tag_wr(tag_wr),
    .fill_done(fill_done)
  );

  cache_fill_fsm #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .miss_detected(miss_b), .miss_address(addr_b),
    .mem_data(data_b), .mem_data_valid(valid_b), .fsm_busy(busy_b),
    .mem_rd_en(rd_en_b), .mem_addr(mem_addr_b), .data_wr(wr_b),
    .data_wr_addr(wr_addr_b), .data_wr_data(wr_data_b), .tag_wr(tag_b),
    .fill_done(done_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 filling, 2 tag write; outstanding work kept as address queues.
  int            m_phase = 0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] req_q[$];
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] mem_a[$];
  int            mem_rdy[$];
  int            cyc = 0;
  int            lat = 4;
  int            gap_pct = 0;
  int            stray_pct = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'hA55A;
  endfunction

  // One clock cycle: drive at negedge, check outputs, advance the model at posedge.
  task automatic cycle(input logic r, input logic miss, input logic [AW-1:0] addr);
    logic          v;
    logic [DW-1:0] d;
    logic          exp_rd;
    logic          exp_wr;
    rst = r;
    miss_detected = miss;
    miss_address = addr;
    v = 1'b0;
    d = DW'($urandom);
    if (mem_rdy.size() > 0 && mem_rdy[0] <= cyc && $urandom_range(99) >= gap_pct) begin
      v = 1'b1;
      d = word_of(mem_a[0]);
    end else if (m_phase != 1 && $urandom_range(99) < stray_pct) begin
      v = 1'b1;
    end
    mem_data_valid = v;
    mem_data = d;
    #1;
    exp_rd = (m_phase == 1) && (req_q.size() > 0);
    exp_wr = (m_phase == 1) && v;
    chk("fsm_busy", fsm_busy, m_phase != 0);
    chk("mem_rd_en", mem_rd_en, exp_rd);
    chk("mem_addr", mem_addr, exp_rd ? req_q[0] : m_base);
    chk("data_wr", data_wr, exp_wr);
    if (exp_wr) begin
      chk("data_wr_addr", data_wr_addr, wr_q[0]);
      chk("data_wr_data", data_wr_data, d);
    end else if (m_phase != 1) begin
      chk("data_wr_addr_hold", data_wr_addr, m_base);
      chk("data_wr_data_zero", data_wr_data, 0);
    end
    chk("tag_wr", tag_wr, m_phase == 2);
    chk("fill_done", fill_done, m_phase == 2);
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_base = '0;
      req_q.delete();
      wr_q.delete();
      mem_a.delete();
      mem_rdy.delete();
    end else begin
      case (m_phase)
        0: if (miss) begin
          m_base = addr & ~AW'(2 * W - 1);
          for (int k = 0; k < W; k++) begin
            req_q.push_back(m_base + AW'(2 * k));
            wr_q.push_back(m_base + AW'(2 * k));
          end
          m_phase = 1;
        end
        1: begin
          if (req_q.size() > 0) begin
            mem_a.push_back(req_q.pop_front());
            mem_rdy.push_back(cyc + lat);
          end
          if (v) begin
            void'(wr_q.pop_front());
            void'(mem_a.pop_front());
            void'(mem_rdy.pop_front());
            if (wr_q.size() == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic finish_fill(input logic miss);
    int guard = 0;
    while (m_phase != 0 && guard < 300) begin
      cycle(1'b0, miss, AW'($urandom));
      guard++;
    end
    chk("fill_timeout_phase", m_phase, 0);
  endtask

  initial begin
    int start;
    int guard;
    @(negedge clk);

    // Reset held two cycles with stray valids, then idle with valids ignored.
    stray_pct = 50;
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, AW'($urandom));

    // Basic fill with fixed 4-cycle latency.
    stray_pct = 0; lat = 4; gap_pct = 0;
    start = cyc;
    cycle(1'b0, 1'b1, 16'h1234);
    finish_fill(1'b0);
    chk("basic_fill_length", cyc - start, 14);
    chk("basic_base_kept", mem_addr, 16'h1230);

    // Gapped returns at random latencies, stray valids in IDLE/TAG.
    stray_pct = 50; gap_pct = 60;
    for (int f = 0; f < 5; f++) begin
      lat = $urandom_range(1, 6);
      cycle(1'b0, 1'b1, AW'($urandom));
      finish_fill(1'b0);
      cycle(1'b0, 1'b0, AW'($urandom));
    end

    // Miss held high with a wandering address: back-to-back fills.
    stray_pct = 0; gap_pct = 0; lat = 2;
    cycle(1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, AW'($urandom));
    finish_fill(1'b0);

    // Reset after the 3rd returned word abandons the block.
    lat = 3;
    cycle(1'b0, 1'b1, 16'h4444);
    guard = 0;
    while (m_phase == 1 && (W - wr_q.size()) < 3 && guard < 50) begin
      cycle(1'b0, 1'b0, 16'h0000);
      guard++;
    end
    chk("three_words_received", W - wr_q.size(), 3);
    cycle(1'b1, 1'b1, 16'h4444);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'hFFFE);
    finish_fill(1'b0);

    // WORDS=2 instance: miss at 0x0003 fetches 0x0000 and 0x0002 only.
    rst = 1'b0; miss_detected = 1'b0; mem_data_valid = 1'b0;
    miss_b = 1'b1; addr_b = 16'h0003;
    #1 chk("w2_idle_busy", busy_b, 0);
    @(posedge clk); @(negedge clk);
    miss_b = 1'b0; addr_b = 16'h7777;
    #1 chk("w2_req0_en", rd_en_b, 1);
    chk("w2_req0_addr", mem_addr_b, 16'h0000);
    chk("w2_busy", busy_b, 1);
    @(posedge clk); @(negedge clk);
    #1 chk("w2_req1_en", rd_en_b, 1);
    chk("w2_req1_addr", mem_addr_b, 16'h0002);
    @(posedge clk); @(negedge clk);
    valid_b = 1'b1; data_b = 16'hBEEF;
    #1 chk("w2_req_stop", rd_en_b, 0);
    chk("w2_req_stop_addr", mem_addr_b, 16'h0000);
    chk("w2_wr0", wr_b, 1);
    chk("w2_wr0_addr", wr_addr_b, 16'h0000);
    chk("w2_wr0_data", wr_data_b, 16'hBEEF);
    chk("w2_no_tag_early", tag_b, 0);
    @(posedge clk); @(negedge clk);
    data_b = 16'hCAFE;
    #1 chk("w2_wr1_addr", wr_addr_b, 16'h0002);
    chk("w2_wr1_data", wr_data_b, 16'hCAFE);
    chk("w2_no_tag_yet", tag_b, 0);
    @(posedge clk); @(negedge clk);
    #1 chk("w2_tag", tag_b, 1);
    chk("w2_done", done_b, 1);
    chk("w2_tag_drop_valid", wr_b, 0);
    @(posedge clk); @(negedge clk);
    valid_b = 1'b0;
    #1 chk("w2_idle_after", busy_b, 0);
    chk("w2_done_pulse", done_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
